// File: rtl/jtframe_prog_packer_if.sv
// rtl/jtframe_prog_packer_if.sv - SDRAM programming bus between the download packer and the SDRAM controller
interface jtframe_prog_packer_if #(
    parameter int SDRAMW = 22
) ();
    logic [SDRAMW-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic [1:0]        prog_mask;
    logic              prog_we;
    logic              prog_rdy;

    modport master (
        output prog_addr,
        output prog_data,
        output prog_mask,
        output prog_we,
        input  prog_rdy
    );

    modport slave (
        input  prog_addr,
        input  prog_data,
        input  prog_mask,
        input  prog_we,
        output prog_rdy
    );
endinterface

// File: rtl/jtframe_prog_packer.sv
// rtl/jtframe_prog_packer.sv - buffers ioctl download bytes into SDRAM byte writes and routes PROM bytes aside
module jtframe_prog_packer #(
    parameter int          SDRAMW     = 22,
    parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
    parameter bit          SWAB       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 downloading,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic                 ioctl_wr,
    jtframe_prog_packer_if.master prog,
    output logic                 prom_we,
    output logic [9:0]           prom_addr,
    output logic [7:0]           prom_data,
    output logic                 dwnld_busy,
    output logic                 ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SDRAMW-1:0] fifo_addr [4];
    logic [7:0]        fifo_data [4];
    logic              fifo_lane [4];

    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    logic       below_prom;
    logic       sdram_byte;
    logic       prom_byte;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       drop;
    logic       load;
    logic       downloading_l;
    logic [9:0] prom_off;

    assign below_prom = ioctl_addr < PROM_START;
    assign sdram_byte = downloading & ioctl_wr & below_prom;
    assign prom_byte  = downloading & ioctl_wr & ~below_prom;
    assign full       = (count == 3'd4);
    assign empty      = (count == 3'd0);
    // Only the low 10 bits of the offset matter, so subtract in 10 bits
    assign prom_off   = ioctl_addr[9:0] - PROM_START[9:0];

    // A full FIFO still accepts a byte when its head leaves in the same cycle
    assign push = sdram_byte & (~full | pop);
    assign drop = sdram_byte & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = ISSUE;
                    load      = 1'b1;
                end
            end
            ISSUE: begin
                if (prog.prog_rdy) begin
                    state_nxt = IDLE;
                    pop       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign prog.prog_we = (state == ISSUE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ioctl_addr[SDRAMW:1];
            fifo_data[wr_ptr] <= ioctl_dout;
            fifo_lane[wr_ptr] <= ioctl_addr[0] ^ SWAB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Bus fields are captured on entry to ISSUE so they hold until prog_rdy
    always_ff @(posedge clk) begin
        if (rst) begin
            prog.prog_addr <= '0;
            prog.prog_data <= 16'd0;
            prog.prog_mask <= 2'b11;
        end else if (load) begin
            prog.prog_addr <= fifo_addr[rd_ptr];
            prog.prog_data <= {fifo_data[rd_ptr], fifo_data[rd_ptr]};
            prog.prog_mask <= {~fifo_lane[rd_ptr], fifo_lane[rd_ptr]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prom_we   <= 1'b0;
            prom_addr <= 10'd0;
            prom_data <= 8'd0;
        end else begin
            prom_we <= prom_byte;
            if (prom_byte) begin
                prom_addr <= prom_off;
                prom_data <= ioctl_dout;
            end
        end
    end

    // A drop in the same cycle as a new download window keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf           <= 1'b0;
            downloading_l <= 1'b0;
        end else begin
            downloading_l <= downloading;
            if (drop) begin
                ovf <= 1'b1;
            end else if (downloading && !downloading_l) begin
                ovf <= 1'b0;
            end
        end
    end

    assign dwnld_busy = ~rst & (downloading | ~empty | prog.prog_we);

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// tb/tb_jtframe_prog_packer.sv - directed self-checking bench for jtframe_prog_packer
module tb_jtframe_prog_packer;

    logic        clk;
    logic        rst;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        prom_we;
    logic [9:0]  prom_addr;
    logic [7:0]  prom_data;
    logic        dwnld_busy;
    logic        ovf;

    int total;
    int bad;

    jtframe_prog_packer_if #(.SDRAMW(22)) pif ();

    jtframe_prog_packer #(
        .SDRAMW    (22),
        .PROM_START(25'h100),
        .SWAB      (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .downloading(downloading),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .ioctl_wr   (ioctl_wr),
        .prog       (pif),
        .prom_we    (prom_we),
        .prom_addr  (prom_addr),
        .prom_data  (prom_data),
        .dwnld_busy (dwnld_busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a write request, captures it, then acknowledges it
    task automatic grab_write(output bit ok, output logic [21:0] a,
                              output logic [15:0] d, output logic [1:0] m);
        ok = 1'b0;
        a  = '0;
        d  = '0;
        m  = '0;
        for (int i = 0; i < 30; i++) begin
            if (pif.prog_we === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (ok) begin
            a = pif.prog_addr;
            d = pif.prog_data;
            m = pif.prog_mask;
            pif.prog_rdy = 1'b1;
            cyc();
            pif.prog_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        downloading = 1'b1;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        pif.prog_rdy = 1'b0;
        cyc();
        cyc();
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL reset_prog_we: got %b want 0", pif.prog_we); end
        total++; if (prom_we !== 1'b0) begin bad++; $display("FAIL reset_prom_we: got %b want 0", prom_we); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        total++; if (pif.prog_addr !== 22'd0) begin bad++; $display("FAIL reset_prog_addr: got %h want 0", pif.prog_addr); end
        total++; if (pif.prog_data !== 16'd0) begin bad++; $display("FAIL reset_prog_data: got %h want 0", pif.prog_data); end
        total++; if (pif.prog_mask !== 2'b11) begin bad++; $display("FAIL reset_prog_mask: got %b want 11", pif.prog_mask); end
        total++; if (prom_addr !== 10'd0 || prom_data !== 8'd0) begin bad++; $display("FAIL reset_prom_bus: got %h/%h want 0/0", prom_addr, prom_data); end
        total++; if (dwnld_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", dwnld_busy); end
        rst = 1'b0;
        #1;
        total++; if (dwnld_busy !== 1'b1) begin bad++; $display("FAIL post_reset_busy: got %b want 1", dwnld_busy); end
        cyc();
    endtask

    task automatic test_single();
        ioctl_addr = 25'h10;
        ioctl_dout = 8'hA5;
        ioctl_wr = 1'b1;
        cyc();
        ioctl_wr = 1'b0;
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL single_latency: got %b want 0", pif.prog_we); end
        cyc();
        total++; if (pif.prog_we !== 1'b1) begin bad++; $display("FAIL single_we: got %b want 1", pif.prog_we); end
        total++; if (pif.prog_addr !== 22'h8) begin bad++; $display("FAIL single_addr: got %h want 8", pif.prog_addr); end
        total++; if (pif.prog_data !== 16'hA5A5) begin bad++; $display("FAIL single_data: got %h want a5a5", pif.prog_data); end
        total++; if (pif.prog_mask !== 2'b10) begin bad++; $display("FAIL single_mask: got %b want 10", pif.prog_mask); end
        for (int i = 0; i < 4; i++) cyc();
        total++; if (pif.prog_we !== 1'b1 || pif.prog_addr !== 22'h8 || pif.prog_data !== 16'hA5A5 || pif.prog_mask !== 2'b10)
            begin bad++; $display("FAIL single_hold: got we=%b addr=%h data=%h mask=%b want 1/8/a5a5/10", pif.prog_we, pif.prog_addr, pif.prog_data, pif.prog_mask); end
        pif.prog_rdy = 1'b1;
        cyc();
        pif.prog_rdy = 1'b0;
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL single_ack: got %b want 0", pif.prog_we); end
        cyc();
        cyc();
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL single_no_repeat: got %b want 0", pif.prog_we); end
    endtask

    task automatic test_back_to_back();
        ioctl_addr = 25'h20;
        ioctl_dout = 8'h11;
        ioctl_wr = 1'b1;
        cyc();
        ioctl_addr = 25'h21;
        ioctl_dout = 8'h22;
        cyc();
        ioctl_wr = 1'b0;
        total++; if (pif.prog_we !== 1'b1 || pif.prog_addr !== 22'h10 || pif.prog_data !== 16'h1111 || pif.prog_mask !== 2'b10)
            begin bad++; $display("FAIL b2b_first: got we=%b addr=%h data=%h mask=%b want 1/10/1111/10", pif.prog_we, pif.prog_addr, pif.prog_data, pif.prog_mask); end
        for (int i = 0; i < 10; i++) cyc();
        pif.prog_rdy = 1'b1;
        cyc();
        pif.prog_rdy = 1'b0;
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b want 0", pif.prog_we); end
        cyc();
        total++; if (pif.prog_we !== 1'b1 || pif.prog_addr !== 22'h10 || pif.prog_data !== 16'h2222 || pif.prog_mask !== 2'b01)
            begin bad++; $display("FAIL b2b_second: got we=%b addr=%h data=%h mask=%b want 1/10/2222/01", pif.prog_we, pif.prog_addr, pif.prog_data, pif.prog_mask); end
        for (int i = 0; i < 10; i++) cyc();
        pif.prog_rdy = 1'b1;
        cyc();
        pif.prog_rdy = 1'b0;
        cyc();
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL b2b_done: got %b want 0", pif.prog_we); end
    endtask

    task automatic test_overflow();
        bit          ok;
        bit          seen;
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        logic [7:0]  b;
        for (int k = 0; k < 6; k++) begin
            ioctl_addr = 25'h30 + 25'(k);
            ioctl_dout = 8'h61 + 8'(k);
            ioctl_wr = 1'b1;
            cyc();
            if (k == 3) begin
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", ovf); end
            end
            if (k == 4) begin
                total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
            end
        end
        ioctl_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            grab_write(ok, a, d, m);
            b = 8'h61 + 8'(k);
            total++; if (!ok) begin bad++; $display("FAIL ovf_write%0d: got no write want write", k); end
            total++; if (a !== 22'((8'h30 + 8'(k)) >> 1) || d !== {b, b} || m !== ((k % 2) ? 2'b01 : 2'b10))
                begin bad++; $display("FAIL ovf_data%0d: got %h/%h/%b want %h/%h/%b", k, a, d, m, (8'h30 + 8'(k)) >> 1, {b, b}, (k % 2) ? 2'b01 : 2'b10); end
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (pif.prog_we === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL ovf_extra_write: got write want none"); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        downloading = 1'b0;
        cyc();
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_fall_keep: got %b want 1", ovf); end
        downloading = 1'b1;
        cyc();
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_full_pop();
        bit          ok;
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        logic [7:0]  b;
        for (int k = 0; k < 4; k++) begin
            ioctl_addr = 25'h60 + 25'(k);
            ioctl_dout = 8'h71 + 8'(k);
            ioctl_wr = 1'b1;
            cyc();
        end
        total++; if (pif.prog_we !== 1'b1 || pif.prog_data !== 16'h7171) begin bad++; $display("FAIL fullpop_head: got %b/%h want 1/7171", pif.prog_we, pif.prog_data); end
        ioctl_addr = 25'h64;
        ioctl_dout = 8'h75;
        pif.prog_rdy = 1'b1;
        cyc();
        ioctl_wr = 1'b0;
        pif.prog_rdy = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
        for (int k = 1; k < 5; k++) begin
            grab_write(ok, a, d, m);
            b = 8'h71 + 8'(k);
            total++; if (!ok || a !== 22'((8'h60 + 8'(k)) >> 1) || d !== {b, b} || m !== ((k % 2) ? 2'b01 : 2'b10))
                begin bad++; $display("FAIL fullpop_write%0d: got ok=%b %h/%h/%b want %h/%h", k, ok, a, d, m, (8'h60 + 8'(k)) >> 1, {b, b}); end
        end
    endtask

    task automatic test_prom();
        bit seen;
        ioctl_addr = 25'h103;
        ioctl_dout = 8'h5C;
        ioctl_wr = 1'b1;
        cyc();
        ioctl_wr = 1'b0;
        total++; if (prom_we !== 1'b1) begin bad++; $display("FAIL prom_we: got %b want 1", prom_we); end
        total++; if (prom_addr !== 10'd3 || prom_data !== 8'h5C) begin bad++; $display("FAIL prom_bus: got %h/%h want 3/5c", prom_addr, prom_data); end
        seen = 1'b0;
        cyc();
        total++; if (prom_we !== 1'b0) begin bad++; $display("FAIL prom_pulse: got %b want 0", prom_we); end
        for (int i = 0; i < 4; i++) begin
            if (pif.prog_we === 1'b1) seen = 1'b1;
            cyc();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL prom_no_sdram: got write want none"); end
    endtask

    task automatic test_drain();
        bit          ok;
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        for (int k = 0; k < 3; k++) begin
            ioctl_addr = 25'h40 + 25'(k);
            ioctl_dout = 8'h01 + 8'(k);
            ioctl_wr = 1'b1;
            cyc();
        end
        ioctl_wr = 1'b0;
        downloading = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (dwnld_busy !== 1'b1) begin bad++; $display("FAIL drain_busy%0d: got %b want 1", k, dwnld_busy); end
            grab_write(ok, a, d, m);
            total++; if (!ok || d !== {8'h01 + 8'(k), 8'h01 + 8'(k)}) begin bad++; $display("FAIL drain_write%0d: got ok=%b data=%h", k, ok, d); end
        end
        total++; if (dwnld_busy !== 1'b0) begin bad++; $display("FAIL drain_idle: got %b want 0", dwnld_busy); end
    endtask

    task automatic test_ignore();
        bit          ok;
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        downloading = 1'b0;
        ioctl_addr = 25'h104;
        ioctl_dout = 8'hEE;
        ioctl_wr = 1'b1;
        cyc();
        total++; if (prom_we !== 1'b0) begin bad++; $display("FAIL ignore_prom: got %b want 0", prom_we); end
        ioctl_addr = 25'h50;
        cyc();
        ioctl_wr = 1'b0;
        cyc();
        total++; if (pif.prog_we !== 1'b0 || dwnld_busy !== 1'b0) begin bad++; $display("FAIL ignore_sdram: got we=%b busy=%b want 0/0", pif.prog_we, dwnld_busy); end
        pif.prog_rdy = 1'b1;
        cyc();
        pif.prog_rdy = 1'b0;
        cyc();
        total++; if (dwnld_busy !== 1'b0 || pif.prog_we !== 1'b0) begin bad++; $display("FAIL idle_rdy: got busy=%b we=%b want 0/0", dwnld_busy, pif.prog_we); end
        downloading = 1'b1;
        ioctl_addr = 25'h52;
        ioctl_dout = 8'h99;
        ioctl_wr = 1'b1;
        cyc();
        ioctl_wr = 1'b0;
        grab_write(ok, a, d, m);
        total++; if (!ok || a !== 22'h29 || d !== 16'h9999 || m !== 2'b10) begin bad++; $display("FAIL after_idle_rdy: got ok=%b %h/%h/%b want 29/9999/10", ok, a, d, m); end
        cyc();
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL after_idle_rdy_empty: got %b want 0", pif.prog_we); end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        bit          seen;
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        for (int k = 0; k < 5; k++) begin
            ioctl_addr = 25'h70 + 25'(k);
            ioctl_dout = 8'h81 + 8'(k);
            ioctl_wr = 1'b1;
            cyc();
        end
        ioctl_wr = 1'b0;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL rstmid_ovf_pre: got %b want 1", ovf); end
        grab_write(ok, a, d, m);
        grab_write(ok, a, d, m);
        cyc();
        total++; if (pif.prog_we !== 1'b1 || pif.prog_data !== 16'h8383) begin bad++; $display("FAIL rstmid_issue: got %b/%h want 1/8383", pif.prog_we, pif.prog_data); end
        rst = 1'b1;
        cyc();
        total++; if (pif.prog_we !== 1'b0 || dwnld_busy !== 1'b0 || ovf !== 1'b0)
            begin bad++; $display("FAIL rstmid_state: got we=%b busy=%b ovf=%b want 0/0/0", pif.prog_we, dwnld_busy, ovf); end
        rst = 1'b0;
        downloading = 1'b0;
        cyc();
        total++; if (dwnld_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", dwnld_busy); end
        pif.prog_rdy = 1'b1;
        cyc();
        pif.prog_rdy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (pif.prog_we === 1'b1 || dwnld_busy === 1'b1) seen = 1'b1;
            cyc();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_residue: got activity want none"); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_prom();
        test_drain();
        test_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtframe_prog_packer.md
JTFRAME_PROG_PACKER -- requirements
Module: jtframe_prog_packer

Interface
REQ-001 Parameter SDRAMW, default 22, SDRAM word-address width.
REQ-002 Parameter PROM_START, default 25'h1FF_FFFF, first ioctl byte address routed to the PROM port instead of SDRAM.
REQ-003 Parameter SWAB, default 0, when 1 inverts the byte-lane choice (odd byte to low lane).
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 downloading  in  1  ROM download window from the I/O controller.
REQ-007 ioctl_addr  in  25  byte address of the current download byte.
REQ-008 ioctl_dout  in  8  download byte.
REQ-009 ioctl_wr  in  1  one-cycle strobe; byte valid this cycle.
REQ-010 prog_addr  out  SDRAMW  SDRAM word address.
REQ-011 prog_data  out  16  write data, byte duplicated on both lanes.
REQ-012 prog_mask  out  2  active-low byte enables; bit1 = high lane, bit0 = low lane.
REQ-013 prog_we  out  1  write request, held until acknowledged.
REQ-014 prog_rdy  in  1  one-cycle SDRAM write-done pulse.
REQ-015 prom_we  out  1  one-cycle PROM write strobe.
REQ-016 prom_addr  out  10  PROM byte offset (ioctl_addr - PROM_START, low 10 bits).
REQ-017 prom_data  out  8  PROM byte.
REQ-018 dwnld_busy  out  1  download or drain in progress.
REQ-019 ovf  out  1  sticky flag: byte dropped because the buffer was full.

Function
REQ-020 SDRAM-bound byte (ioctl_addr < PROM_START) SHALL enter a 4-entry FIFO of {word addr = ioctl_addr[SDRAMW:1], byte, lane = ioctl_addr[0]^SWAB}.
REQ-021 States: IDLE (prog_we=0), ISSUE (prog_we=1, waiting for prog_rdy); IDLE->ISSUE the cycle after FIFO non-empty; ISSUE->IDLE on prog_rdy, popping the head entry.
REQ-022 In ISSUE, prog_addr/prog_data/prog_mask SHALL stay stable until prog_rdy.
REQ-023 prog_mask = 2'b10 for lane 0 (low byte written), 2'b01 for lane 1; prog_data = {byte, byte}.
REQ-024 Back-to-back entries: after prog_rdy, prog_we SHALL be 0 for exactly one cycle before the next ISSUE.
REQ-025 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-026 ioctl_wr with FIFO full (4 entries, no simultaneous pop) SHALL drop the byte and set ovf; with a simultaneous pop the byte SHALL be accepted.
REQ-027 ioctl_wr with downloading=0 SHALL be ignored.
REQ-028 PROM-bound byte SHALL assert prom_we the next cycle for one cycle with prom_addr/prom_data latched; PROM bytes bypass the FIFO.
REQ-029 FIFO pointers are 2-bit and wrap modulo 4; occupancy count is 3-bit (0..4).
REQ-030 dwnld_busy = downloading OR FIFO non-empty OR prog_we; it SHALL fall only after the last prog_rdy following downloading falling.
REQ-031 prog_rdy in IDLE SHALL be ignored.
REQ-032 ovf SHALL clear only on reset or on a rising edge of downloading.

Reset
REQ-033 While rst=1: FIFO empty, state IDLE, prog_we=0, prom_we=0, ovf=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prom_addr=0, prom_data=0.
REQ-034 dwnld_busy SHALL be 0 while rst=1 regardless of downloading; from the first cycle after rst falls it SHALL follow REQ-030.
REQ-035 Reset asserted mid-ISSUE SHALL drop prog_we the next edge and discard all buffered bytes; a later prog_rdy SHALL be ignored.

Verification
REQ-036 downloading=1, ioctl_wr at addr 0x000010 data 0xA5 -> prog_we=1, prog_addr=0x8, prog_data=0xA5A5, prog_mask=2'b10; prog_rdy after 5 cycles -> prog_we=0 next cycle.
REQ-037 Bytes 0x11,0x22 at addrs 0x20,0x21, prog_rdy delayed 10 cycles each -> two writes in order, prog_addr 0x10 both times, masks 2'b10 then 2'b01, one idle cycle between.
REQ-038 Six bytes on consecutive cycles, prog_rdy held 0 -> first four buffered, ovf=1 on the fifth; after prog_rdy pulses, exactly four writes emerge.
REQ-039 PROM_START=0x100, byte 0x5C at addr 0x103 -> prom_we one cycle, prom_addr=3, prom_data=0x5C; no prog_we.
REQ-040 Three bytes queued, downloading falls -> dwnld_busy stays 1 until the third prog_rdy, 0 the next cycle.
REQ-041 rst pulsed while prog_we=1 with 2 entries queued -> prog_we=0, dwnld_busy=0, ovf=0; subsequent prog_rdy produces no write.
